// File: rtl/kb_pkg.sv
// kb_pkg: shared types and helpers for the 4x4 keypad scan controller.
//   kb_state_t  - scan sequencer states
//   KB_N        - keypad rows/columns
//   KB_KEYS     - total keys
//   kb_evt_t    - queued key event {code, press}
//   kb_key_idx  - key index row*4 + col
package kb_pkg;

  localparam int unsigned KB_N    = 4;
  localparam int unsigned KB_KEYS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SCAN
  } kb_state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } kb_evt_t;

  function automatic logic [3:0] kb_key_idx(input logic [1:0] row,
                                            input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// kb_evt_fifo: first-word-fall-through FIFO for key events.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset, empties the FIFO
//   push  - write din (accepted when not full, or when full with a pop)
//   din   - write data
//   full  - no free entry
//   pop   - consume the head entry (ignored when empty)
//   dout  - head entry; holds the last popped value while empty
//   empty - no valid entry
module kb_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kb_scan_ctrl.sv
// kb_scan_ctrl: 4x4 keypad scan sequencer with per-key debounce and an
// event FIFO.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   scan_en   - 1 = keep scanning; 0 = park after the current column
//   kb_row    - raw active-low row inputs (asynchronous)
//   kb_col    - active-low column drive, one-cold while scanning
//   key_valid - event FIFO non-empty
//   key_ready - consumer accepts the head event
//   key_code  - head event key index (row*4 + col)
//   key_press - head event type, 1 = press, 0 = release
//   key_state - debounced key state, bit k = key k held
// Build option: KB_RELEASE_EVT_EN - when defined, releases are queued as
// events too; otherwise only presses are queued.
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DEB_SCANS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [3:0]  kb_row,
  output logic [3:0]  kb_col,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_code,
  output logic        key_press,
  output logic [15:0] key_state
);

  localparam int unsigned CW = $clog2(DEB_SCANS + 1);
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] DEB_MAX     = CW'(DEB_SCANS);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  kb_state_t     state, state_nxt;
  logic [1:0]    col, col_nxt;
  logic [1:0]    row, row_nxt;
  logic [SW-1:0] settle, settle_nxt;
  logic [3:0]    kb_col_nxt;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [3:0]    samp;

  logic [CW-1:0] cnt [KB_KEYS];
  logic [3:0]    k;
  logic          cur;
  logic [CW-1:0] cnt_inc;
  logic          cnt_wr;
  logic [CW-1:0] cnt_val;
  logic          toggle;
  logic          evt_push;
  logic          evt_needed;
  logic          advance;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  kb_evt_t       evt_in;
  kb_evt_t       evt_out;

  assign samp    = ~row_sync;
  assign k       = kb_key_idx(row, col);
  assign cur     = key_state[k];
  assign cnt_inc = cnt[k] + 1'b1;
  assign pop     = key_valid && key_ready;

`ifdef KB_RELEASE_EVT_EN
  assign evt_needed = 1'b1;
`else
  // Only a transition to pressed (current state 0) produces an event.
  assign evt_needed = ~cur;
`endif

  assign evt_in.code  = k;
  assign evt_in.press = ~cur;

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    settle_nxt = settle;
    kb_col_nxt = kb_col;
    cnt_wr     = 1'b0;
    cnt_val    = '0;
    toggle     = 1'b0;
    evt_push   = 1'b0;
    advance    = 1'b0;

    case (state)
      ST_IDLE: begin
        kb_col_nxt = '1;
        if (scan_en) begin
          state_nxt  = ST_DRIVE;
          settle_nxt = '0;
          kb_col_nxt = ~(4'b0001 << col);
        end
      end

      ST_DRIVE: begin
        if (settle == SETTLE_LAST) begin
          state_nxt = ST_SCAN;
          row_nxt   = '0;
        end else begin
          settle_nxt = settle + 1'b1;
        end
      end

      ST_SCAN: begin
        if (samp[row] == cur) begin
          cnt_wr  = 1'b1;
          cnt_val = '0;
          advance = 1'b1;
        end else if (cnt_inc == DEB_MAX) begin
          // Hold the row (no state/counter change) until the FIFO can take it.
          if (!evt_needed || !fifo_full || pop) begin
            cnt_wr   = 1'b1;
            cnt_val  = '0;
            toggle   = 1'b1;
            evt_push = evt_needed;
            advance  = 1'b1;
          end
        end else begin
          cnt_wr  = 1'b1;
          cnt_val = cnt_inc;
          advance = 1'b1;
        end

        if (advance) begin
          if (row == 2'd3) begin
            col_nxt = col + 1'b1;
            if (scan_en) begin
              state_nxt  = ST_DRIVE;
              settle_nxt = '0;
              kb_col_nxt = ~(4'b0001 << col_nxt);
            end else begin
              state_nxt  = ST_IDLE;
              kb_col_nxt = '1;
            end
          end else begin
            row_nxt = row + 1'b1;
          end
        end
      end

      default: begin
        state_nxt  = ST_IDLE;
        kb_col_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= kb_row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      settle <= '0;
      kb_col <= '1;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      settle <= settle_nxt;
      kb_col <= kb_col_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_state <= '0;
      for (int unsigned i = 0; i < KB_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (cnt_wr) begin
        cnt[k] <= cnt_val;
      end
      if (toggle) begin
        key_state[k] <= ~cur;
      end
    end
  end

  kb_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kb_evt_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_push),
    .din   (evt_in),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (evt_out),
    .empty (fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = evt_out.code;
  assign key_press = evt_out.press;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// tb_kb_scan_ctrl: scoreboard bench for kb_scan_ctrl with SETTLE_CYC=4,
// DEB_SCANS=2, FIFO_DEPTH=4 (32-cycle frame). A keypad model drives kb_row
// from the pressed-key vector and kb_col; expected events are queued when
// stimulus is applied and popped by a monitor on every accepted event.
module tb_kb_scan_ctrl;
  import kb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_en = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  kb_row;
  logic [3:0]  kb_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_press;
  logic [15:0] key_state;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad   = 0;
  kb_evt_t exp_q[$];
  kb_evt_t mon_e;

`ifdef KB_RELEASE_EVT_EN
  localparam bit REL_EVT = 1'b1;
`else
  localparam bit REL_EVT = 1'b0;
`endif

  always #5 clk = ~clk;

  kb_scan_ctrl #(
    .SETTLE_CYC (4),
    .DEB_SCANS  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .kb_row    (kb_row),
    .kb_col    (kb_col),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_press (key_press),
    .key_state (key_state)
  );

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    kb_row = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kb_col[c]) kb_row[r] = 1'b0;
      end
    end
  end

  function automatic kb_evt_t mk(input logic [3:0] code, input logic press);
    kb_evt_t e;
    e.code  = code;
    e.press = press;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for kb_col to reach v (bounded).
  task automatic wait_col(input string name, input logic [3:0] v);
    int n = 0;
    while (kb_col !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (kb_col !== v) begin
      bad++;
      $display("FAIL %s timeout: got %0h want %0h", name, kb_col, v);
    end
  endtask

  // Wait for a fresh entry into column drive v (start of its DRIVE phase).
  task automatic wait_col_enter(input string name, input logic [3:0] v);
    int n = 0;
    while (kb_col === v && n < 400) begin
      @(negedge clk);
      n++;
    end
    wait_col(name, v);
  endtask

  // Monitor: compare every accepted head event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && key_valid && key_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_evt: got code=%0d press=%0d want none",
                   key_code, key_press);
        end else begin
          mon_e = exp_q.pop_front();
          if ({key_code, key_press} !== mon_e) begin
            bad++;
            $display("FAIL evt_order: got code=%0d press=%0d want code=%0d press=%0d",
                     key_code, key_press, mon_e.code, mon_e.press);
          end
        end
      end
    end
  end

  initial begin
    // Reset with scan_en high.
    rst = 1'b0; scan_en = 1'b1; key_ready = 1'b1;
    cyc(3);
    check("rst_kb_col", 32'(kb_col), 32'hF);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_state", 32'(key_state), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_press", 32'(key_press), 32'h0);
    rst = 1'b1;
    cyc(1);
    check("first_col", 32'(kb_col), 32'hE);

    // Glitch: key 6 held for exactly one scan of column 2.
    wait_col_enter("glitch_sync", 4'b1011);
    pressed[6] = 1'b1;
    cyc(30);
    pressed[6] = 1'b0;
    cyc(70);
    check("glitch_state", 32'(key_state), 32'h0);
    check("glitch_valid", 32'(key_valid), 32'h0);

    // Press key 6 (row1/col2) for three frames: one event in frame 2.
    wait_col_enter("press_sync", 4'b1011);
    pressed[6] = 1'b1;
    exp_q.push_back(mk(4'h6, 1'b1));
    cyc(96);
    check("press_state", 32'(key_state), 32'h0040);
    check("press_drained", 32'(exp_q.size()), 32'h0);
    check("hold_code", 32'(key_code), 32'h6);
    check("hold_press", 32'(key_press), 32'h1);

    // Release key 6.
    pressed[6] = 1'b0;
    if (REL_EVT) exp_q.push_back(mk(4'h6, 1'b0));
    cyc(110);
    check("release_state", 32'(key_state), 32'h0);
    check("release_drained", 32'(exp_q.size()), 32'h0);
    check("release_press", 32'(key_press), REL_EVT ? 32'h0 : 32'h1);

    // Backpressure: five presses, FIFO holds four, scan stalls at key 1.
    key_ready = 1'b0;
    wait_col_enter("bp_sync", 4'b1110);
    pressed = 16'h1113;
    exp_q.push_back(mk(4'd0, 1'b1));
    exp_q.push_back(mk(4'd4, 1'b1));
    exp_q.push_back(mk(4'd8, 1'b1));
    exp_q.push_back(mk(4'd12, 1'b1));
    exp_q.push_back(mk(4'd1, 1'b1));
    cyc(110);
    check("bp_stall_col", 32'(kb_col), 32'hD);
    check("bp_state", 32'(key_state), 32'h1111);
    check("bp_valid", 32'(key_valid), 32'h1);
    check("bp_head", 32'(key_code), 32'h0);
    key_ready = 1'b1;
    cyc(40);
    check("bp_state_after", 32'(key_state), 32'h1113);
    check("bp_drained", 32'(exp_q.size()), 32'h0);

    // Release all five together.
    wait_col_enter("rel_all_sync", 4'b1110);
    pressed = '0;
    if (REL_EVT) begin
      exp_q.push_back(mk(4'd0, 1'b0));
      exp_q.push_back(mk(4'd4, 1'b0));
      exp_q.push_back(mk(4'd8, 1'b0));
      exp_q.push_back(mk(4'd12, 1'b0));
      exp_q.push_back(mk(4'd1, 1'b0));
    end
    cyc(100);
    check("rel_all_state", 32'(key_state), 32'h0);
    check("rel_all_drained", 32'(exp_q.size()), 32'h0);

    // scan_en dropped during DRIVE of column 1: park after its SCAN.
    wait_col_enter("park_sync", 4'b1101);
    scan_en = 1'b0;
    cyc(7);
    check("park_hold", 32'(kb_col), 32'hD);
    cyc(1);
    check("park_idle", 32'(kb_col), 32'hF);
    cyc(20);
    check("park_stay", 32'(kb_col), 32'hF);
    scan_en = 1'b1;
    cyc(1);
    check("resume_col2", 32'(kb_col), 32'hB);

    // Reset mid-scan discards a queued event.
    key_ready = 1'b0;
    wait_col_enter("rst_mid_sync", 4'b1110);
    pressed[0] = 1'b1;
    cyc(70);
    check("rst_mid_queued", 32'(key_valid), 32'h1);
    pressed = '0;
    rst = 1'b0;
    cyc(2);
    check("rst_mid_valid", 32'(key_valid), 32'h0);
    check("rst_mid_state", 32'(key_state), 32'h0);
    check("rst_mid_col", 32'(kb_col), 32'hF);
    rst = 1'b1;
    key_ready = 1'b1;
    cyc(100);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    check("final_valid", 32'(key_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
